// File: rtl/calc_pkg.sv
// Shared constants for calc_port_responder: command codes, response codes and FSM state encoding.
`timescale 1ns/1ps
package calc_pkg;

   localparam logic [3:0] CMD_NOP = 4'd0;
   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;

   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_OK   = 2'd1;
   localparam logic [1:0] RESP_ERR  = 2'd2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_OPND2 = 2'd1;
   localparam logic [1:0] ST_EXEC  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/calc_resp_alu.sv
// Combinational result/response generator for calc_port_responder.
// Shift commands exist only when CALC_RESP_SHIFT_EN is defined; otherwise they fall into the invalid path.
`timescale 1ns/1ps
module calc_resp_alu
   import calc_pkg::*;
(
   input  logic [0:3]  cmd,
   input  logic [0:31] op1,
   input  logic [0:31] op2,
   output logic [0:1]  resp,
   output logic [0:31] data
);

   logic [32:0] sum;

   always_comb begin
      sum  = {1'b0, op1} + {1'b0, op2};
      resp = RESP_ERR;
      data = '0;
      case (cmd)
         CMD_ADD: begin
            if (!sum[32]) begin
               resp = RESP_OK;
               data = sum[31:0];
            end
         end
         CMD_SUB: begin
            if (op2 <= op1) begin
               resp = RESP_OK;
               data = op1 - op2;
            end
         end
`ifdef CALC_RESP_SHIFT_EN
         // op2[27:31] are the five least-significant bits of the big-endian operand
         CMD_SHL: begin
            resp = RESP_OK;
            data = op1 << op2[27:31];
         end
         CMD_SHR: begin
            resp = RESP_OK;
            data = op1 >> op2[27:31];
         end
`endif
         default: begin
            resp = RESP_ERR;
            data = '0;
         end
      endcase
   end

endmodule

// File: rtl/calc_port_responder.sv
// Two-beat command port: command+operand1, then operand2, then a fixed-latency one-cycle response.
// Optional shift support is enabled by defining CALC_RESP_SHIFT_EN (see calc_resp_alu).
`timescale 1ns/1ps
module calc_port_responder
   import calc_pkg::*;
#(
   parameter int unsigned LATENCY = 3
)
(
   input  logic        c_clk,
   input  logic        reset,
   input  logic [0:3]  req_cmd_in,
   input  logic [0:31] req_data_in,
   output logic [0:1]  out_resp,
   output logic [0:31] out_data,
   output logic        busy
);

   localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [0:3]  cmd_q, cmd_d;
   logic [0:31] op1_q, op1_d;
   logic [0:31] op2_q, op2_d;
   logic [0:1]  alu_resp;
   logic [0:31] alu_data;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      case (state_q)
         ST_IDLE: begin
            if (req_cmd_in != CMD_NOP) begin
               cmd_d   = req_cmd_in;
               op1_d   = req_data_in;
               state_d = ST_OPND2;
            end
         end
         ST_OPND2: begin
            op2_d   = req_data_in;
            cnt_d   = 4'd1;
            // EXEC occupies LATENCY-1 cycles, so LATENCY=1 skips it entirely
            state_d = (LATENCY == 1) ? ST_RESP : ST_EXEC;
         end
         ST_EXEC: begin
            if (cnt_q == LAT_LAST) state_d = ST_RESP;
            else                   cnt_d   = cnt_q + 4'd1;
         end
         ST_RESP: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cmd_q   <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
      end
   end

   calc_resp_alu u_alu (
      .cmd  (cmd_q),
      .op1  (op1_q),
      .op2  (op2_q),
      .resp (alu_resp),
      .data (alu_data)
   );

   // Outputs decode from the reset-cleared state, so asserting reset silences them at once
   assign busy     = (state_q != ST_IDLE);
   assign out_resp = (state_q == ST_RESP) ? alu_resp : RESP_NONE;
   assign out_data = (state_q == ST_RESP) ? alu_data : '0;

endmodule

// File: tb/tb_calc_port_responder.sv
// Scoreboard bench for calc_port_responder: LATENCY=3 main instance plus LATENCY=1/15 back-to-back lanes.
`timescale 1ns/1ps
module tb_calc_port_responder;

   localparam int unsigned LAT   = 3;
   localparam int unsigned N_B2B = 1000;

   typedef struct {
      logic [1:0]  r;
      logic [31:0] d;
      int unsigned due;
   } exp_t;

   logic        c_clk = 1'b0;
   logic        rst;
   logic        rst_l;
   logic [0:3]  cmd;
   logic [0:31] din;
   logic [0:1]  resp;
   logic [0:31] dout;
   logic        busy;

   logic [0:3]  l1_cmd, l15_cmd;
   logic [0:31] l1_din, l15_din;
   logic [0:1]  l1_resp, l15_resp;
   logic [0:31] l1_dout, l15_dout;
   logic        l1_busy, l15_busy;

   int unsigned cyc = 0;
   int          checks = 0;
   int          failures = 0;
   exp_t        q[$];
   exp_t        q1[$];
   exp_t        q15[$];
   exp_t        m_e, m1_e, m15_e;

   always #5 c_clk = ~c_clk;
   always @(posedge c_clk) cyc <= cyc + 1;

   calc_port_responder #(.LATENCY(LAT)) u_dut (
      .c_clk(c_clk), .reset(rst), .req_cmd_in(cmd), .req_data_in(din),
      .out_resp(resp), .out_data(dout), .busy(busy)
   );

   calc_port_responder #(.LATENCY(1)) u_lat1 (
      .c_clk(c_clk), .reset(rst_l), .req_cmd_in(l1_cmd), .req_data_in(l1_din),
      .out_resp(l1_resp), .out_data(l1_dout), .busy(l1_busy)
   );

   calc_port_responder #(.LATENCY(15)) u_lat15 (
      .c_clk(c_clk), .reset(rst_l), .req_cmd_in(l15_cmd), .req_data_in(l15_din),
      .out_resp(l15_resp), .out_data(l15_dout), .busy(l15_busy)
   );

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endfunction

   // Reference: result derived directly from the command rules with 64-bit arithmetic
   function automatic void ref_calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                    output logic [1:0] r, output logic [31:0] d);
      logic [63:0] wide;
      r    = 2'd2;
      d    = '0;
      wide = {32'd0, a} + {32'd0, b};
      case (c)
         4'd1: if (wide <= 64'hFFFF_FFFF) begin r = 2'd1; d = wide[31:0]; end
         4'd2: if (b <= a) begin r = 2'd1; d = a - b; end
`ifdef CALC_RESP_SHIFT_EN
         4'd5: begin r = 2'd1; d = a << (b % 32); end
         4'd6: begin r = 2'd1; d = a >> (b % 32); end
`endif
         default: begin r = 2'd2; d = '0; end
      endcase
   endfunction

   task automatic tick();
      @(posedge c_clk);
      #1;
   endtask

   // Monitors: every nonzero response must match the oldest expectation, on its due cycle
   always @(negedge c_clk) begin
      if (rst) begin
         chk("reset_outputs", {30'd0, resp, dout, busy}, 64'd0);
      end else if (resp == 2'd0) begin
         chk("idle_data_zero", dout, 64'd0);
      end else if (q.size() == 0) begin
         chk("unexpected_resp", resp, 64'd0);
      end else begin
         m_e = q.pop_front();
         chk("resp_code", resp, m_e.r);
         chk("resp_data", dout, m_e.d);
         chk("resp_cycle", cyc, m_e.due);
      end
   end

   always @(negedge c_clk) begin
      if (!rst_l && l1_resp != 2'd0) begin
         if (q1.size() == 0) chk("lat1_unexpected_resp", l1_resp, 64'd0);
         else begin
            m1_e = q1.pop_front();
            chk("lat1_resp_code", l1_resp, m1_e.r);
            chk("lat1_resp_data", l1_dout, m1_e.d);
            chk("lat1_resp_cycle", cyc, m1_e.due);
         end
      end
   end

   always @(negedge c_clk) begin
      if (!rst_l && l15_resp != 2'd0) begin
         if (q15.size() == 0) chk("lat15_unexpected_resp", l15_resp, 64'd0);
         else begin
            m15_e = q15.pop_front();
            chk("lat15_resp_code", l15_resp, m15_e.r);
            chk("lat15_resp_data", l15_dout, m15_e.d);
            chk("lat15_resp_cycle", cyc, m15_e.due);
         end
      end
   end

   task automatic wait_idle();
      int unsigned n = 0;
      while (busy && n < 40) begin
         cmd = 4'($urandom_range(1, 15));
         din = $urandom;
         tick();
         n++;
      end
      if (busy) chk("idle_timeout", busy, 64'd0);
      cmd = '0;
   endtask

   // Issue one command; nonzero noise is driven on the command port for every busy cycle
   task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input bit wait_first);
      exp_t        e;
      int unsigned blen;
      if (wait_first) wait_idle();
      ref_calc(c, a, b, e.r, e.d);
      e.due = cyc + 1 + LAT;
      q.push_back(e);
      cmd = c;
      din = a;
      tick();
      cmd  = 4'($urandom_range(1, 15));
      din  = b;
      blen = 0;
      while (busy && blen < 40) begin
         blen++;
         tick();
         cmd = 4'($urandom_range(1, 15));
         din = $urandom;
      end
      cmd = '0;
      chk("busy_len", blen, LAT + 1);
   endtask

   function automatic logic lane_busy(input int lane);
      return (lane == 0) ? l1_busy : l15_busy;
   endfunction

   task automatic lane_drive(input int lane, input logic [3:0] c, input logic [31:0] d);
      if (lane == 0) begin l1_cmd = c; l1_din = d; end
      else begin l15_cmd = c; l15_din = d; end
   endtask

   task automatic lane_run(input int lane);
      exp_t        e;
      int unsigned n;
      int unsigned lat = (lane == 0) ? 1 : 15;
      for (int unsigned x = 1; x <= N_B2B; x++) begin
         n = 0;
         while (lane_busy(lane) && n < 40) begin tick(); n++; end
         if (lane_busy(lane)) chk("lane_idle_timeout", lane, 64'hFF);
         e.r   = 2'd1;
         e.d   = x + 1;
         e.due = cyc + 1 + lat;
         if (lane == 0) q1.push_back(e); else q15.push_back(e);
         lane_drive(lane, 4'd1, 32'd1);
         tick();
         lane_drive(lane, 4'd0, x);
         tick();
         lane_drive(lane, 4'd0, 32'd0);
      end
   endtask

   task automatic main_seq();
      exp_t        e;
      logic [31:0] a, b;
      // First command lands on the first edge after reset release
      issue(4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 1'b0);
      issue(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
      issue(4'd1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
      issue(4'd1, 32'h8000_0000, 32'h8000_0000, 1'b1);
      issue(4'd2, 32'h1, 32'hF, 1'b1);
      issue(4'd2, 32'hF, 32'h1, 1'b1);
      issue(4'd2, 32'h1234_5678, 32'h1234_5678, 1'b1);
      issue(4'd3, 32'h1, 32'h1, 1'b1);
      issue(4'd4, 32'h1, 32'h1, 1'b1);
      issue(4'd7, 32'h1, 32'h1, 1'b1);
      issue(4'd15, 32'h1, 32'h1, 1'b1);
      issue(4'd5, 32'h1, 32'd4, 1'b1);
      issue(4'd6, 32'h8000_0000, 32'd31, 1'b1);
      issue(4'd5, 32'hDEAD_BEEF, 32'd0, 1'b1);
      issue(4'd6, 32'hDEAD_BEEF, 32'd0, 1'b1);
      issue(4'd5, 32'hF000_000F, 32'h0000_0023, 1'b1);

      wait_idle();
      for (int i = 0; i < 5; i++) begin
         cmd = '0;
         din = $urandom;
         tick();
         chk("nop_busy_low", busy, 64'd0);
      end

      // Reset two cycles into a command, then a command on the first edge after release
      wait_idle();
      cmd = 4'd1; din = 32'd1; tick();
      cmd = 4'd1; din = 32'd2; tick();
      chk("pre_reset_busy", busy, 64'd1);
      rst = 1'b1;
      #1;
      chk("async_reset_busy", busy, 64'd0);
      tick();
      rst = 1'b0;
      issue(4'd1, 32'h10, 32'h20, 1'b0);

      // Reset while the response is on the port
      wait_idle();
      cmd = 4'd1; din = 32'd5; tick();
      cmd = 4'd0; din = 32'd6;
      repeat (LAT) tick();
      chk("pre_reset_resp", resp, 64'd1);
      rst = 1'b1;
      #1;
      chk("reset_in_resp", {30'd0, resp, dout, busy}, 64'd0);
      tick();
      rst = 1'b0;
      issue(4'd2, 32'h100, 32'h1, 1'b0);

      for (int i = 0; i < 300; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         issue(4'($urandom_range(1, 15)), a, b, 1'b1);
      end
      wait_idle();
      e.r = 2'd0;
   endtask

   initial begin
      rst     = 1'b1;
      rst_l   = 1'b1;
      cmd     = '0;
      din     = '0;
      l1_cmd  = '0;
      l1_din  = '0;
      l15_cmd = '0;
      l15_din = '0;
      repeat (3) tick();
      chk("reset_busy", busy, 64'd0);
      chk("reset_resp", resp, 64'd0);
      chk("reset_data", dout, 64'd0);
      rst   = 1'b0;
      rst_l = 1'b0;
      fork
         main_seq();
         lane_run(0);
         lane_run(1);
      join
      repeat (20) tick();
      chk("main_queue_drained", q.size(), 64'd0);
      chk("lat1_queue_drained", q1.size(), 64'd0);
      chk("lat15_queue_drained", q15.size(), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/calc_port_responder.md
CALC_PORT_RESPONDER -- requirements
Module: calc_port_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 3, giving the cycles from second-operand capture to the response cycle (legal 1..15).
REQ-002 The block SHALL have port c_clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-004 The block SHALL have port req_cmd_in, input, [0:3], the command code (0 no-op, 1 add, 2 sub, 5 shift-left, 6 shift-right, others invalid).
REQ-005 The block SHALL have port req_data_in, input, [0:31], carrying operand1 in the command cycle and operand2 in the following cycle.
REQ-006 The block SHALL have port out_resp, output, [0:1], the response code (0 none, 1 success, 2 error, 3 never driven).
REQ-007 The block SHALL have port out_data, output, [0:31], the result, valid only when out_resp is nonzero.
REQ-008 The block SHALL have port busy, output, 1 bit, high while a command is in flight.

Function
REQ-009 The FSM SHALL have states IDLE, OPND2, EXEC and RESP.
REQ-010 In IDLE, a nonzero req_cmd_in in cycle T SHALL capture the command and operand1, and SHALL move the FSM to OPND2.
REQ-011 In OPND2 (cycle T+1), the block SHALL capture operand2 regardless of req_cmd_in, then move to EXEC.
REQ-012 EXEC SHALL count LATENCY-1 cycles, then move to RESP, so the response appears in cycle T+1+LATENCY.
REQ-013 RESP SHALL last exactly one cycle, driving out_resp and out_data, then return to IDLE; the earliest next command is accepted in the cycle after RESP.
REQ-014 Outside RESP, out_resp SHALL be 0 and out_data SHALL be 0.
REQ-015 busy SHALL be high in OPND2, EXEC and RESP, and low in IDLE.
REQ-016 Nonzero commands presented while busy is high SHALL be ignored: no capture, no response, no state change.
REQ-017 Add SHALL compute a 33-bit sum; a carry-out gives resp 2 with data 0, otherwise resp 1 with the 32-bit sum.
REQ-018 Sub SHALL give resp 2 with data 0 when operand2 > operand1 (unsigned), otherwise resp 1 with operand1 - operand2.
REQ-019 Shift-left and shift-right SHALL shift operand1 logically by operand2 bits [27:31] (0..31), zero-filling, with resp 1; shifted-out bits are not an error.
REQ-020 A shift amount of 0 SHALL return operand1 unchanged with resp 1.
REQ-021 Invalid commands (3, 4, 7..15) SHALL still consume both operand cycles and the full latency, then give resp 2 with data 0.
REQ-022 Command 0 in IDLE SHALL leave the FSM in IDLE with no response.

Reset
REQ-023 Asserting reset SHALL immediately force state IDLE, out_resp 0, out_data 0, busy 0, and clear the latency counter and operand registers.
REQ-024 Reset asserted mid-operation, including during RESP, SHALL abort the command with no response, before or after deassertion.
REQ-025 The first command SHALL be accepted in the first rising edge after reset deasserts.

Configuration
REQ-026 With CALC_RESP_SHIFT_EN defined, commands 5 and 6 SHALL behave as in REQ-019 and REQ-020.
REQ-027 Without CALC_RESP_SHIFT_EN, commands 5 and 6 SHALL be treated as invalid (REQ-021) and no shifter logic SHALL be synthesised.

Structure
REQ-028 Package calc_pkg SHALL hold the command code constants (CMD_NOP, CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR), the response code constants (RESP_NONE, RESP_OK, RESP_ERR), and the FSM state encoding.
REQ-029 Combinational arithmetic SHALL live in sub-module calc_resp_alu (command, operand1, operand2 -> resp, data).
REQ-030 The FSM and the latency counter SHALL remain in the top module.

Verification (LATENCY=3 unless noted)
REQ-031 Add 0x00000001 + 0x1FFFFFFF issued at cycle T SHALL give out_resp=1 and out_data=0x20000000 at T+4 only, with busy high over T+1..T+4.
REQ-032 Add 0xFFFFFFFF + 0x00000001 SHALL give out_resp=2 and out_data=0; sub 0x1 - 0xF SHALL give out_resp=2; sub 0xF - 0x1 SHALL give out_resp=1 and out_data=0xE.
REQ-033 Commands 3 and 4 with operands 0x1 SHALL give out_resp=2 at T+4; command 0 SHALL produce no response and keep busy low.
REQ-034 Shift-left 0x1 by 4 SHALL give out_data=0x10 and shift-right 0x80000000 by 31 SHALL give out_data=0x1, both with resp 1; in a build without CALC_RESP_SHIFT_EN, both SHALL give out_resp=2.
REQ-035 A second add issued at T+2 while busy SHALL be ignored, yielding exactly one response; reset pulsed at T+2 SHALL yield no response, and a command at the first edge after reset SHALL complete normally.
REQ-036 Back-to-back adds 1+x for x=1..1000 (LATENCY=1 and LATENCY=15), each issued at the first IDLE cycle, SHALL all return resp 1 with data x+1.
